vga_frame_scanner: RTL and testbench
====================================

# vga_frame_scanner

Parametrised VGA display controller that replaces the single-bit, hard-wired-640×480 display path. It generates sync timing from a pixel-clock enable, scans a multi-bit-per-pixel image held in an external double-buffered frame memory, and upscales it by integer pixel replication. It sits between the edge-detector frame store, which writes the image, and the VGA pins.

## Interface
Parameters:
- H_ACTIVE, H_FP, H_SYNC, H_BP: defaults 640, 16, 96, 48. Horizontal timing in pixels.
- V_ACTIVE, V_FP, V_SYNC, V_BP: defaults 480, 10, 2, 33. Vertical timing in lines.
- CLK_DIV: default 4. ClkPort cycles per pixel. Must be ≥2.
- IMG_W, IMG_H: defaults 160, 120. Stored image size.
- SCALE: default 2. Integer replication factor. Requires IMG_W·SCALE ≤ H_ACTIVE and IMG_H·SCALE ≤ V_ACTIVE.
- DEPTH: default 4. Bits per stored pixel. Must be ≥3.
- BORDER: default 9'b000_000_011. {r,g,b} colour for active area outside the image.
- ADDR_W: default $clog2(2·IMG_W·IMG_H). Frame-memory address width.

Ports (clock and reset first):
- ClkPort, in, 1. Board clock; the only clock.
- reset_n, in, 1. Asynchronous, active-low reset.
- rd_addr, out, ADDR_W. Frame-memory read address.
- rd_data, in, DEPTH. Pixel data, valid exactly 1 ClkPort cycle after rd_addr.
- swap_req, in, 1. Level request to flip display bank.
- swap_ack, out, 1. One-cycle pulse when the bank flips.
- frame_start, out, 1. One-cycle pulse at pixel (0,0).
- vga_h_sync, vga_v_sync, out, 1 each. Active-low syncs.
- vga_r, vga_g, vga_b, out, 3 each. Colour.

## Operation
- pix_ce: a mod-CLK_DIV counter asserts pix_ce for one cycle when the count is 0. All scan state advances only on pix_ce.
- h_cnt counts 0..H_TOTAL−1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. It wraps to 0 and increments v_cnt. v_cnt counts 0..V_TOTAL−1 and then wraps.
- hsync is low while h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule with the V parameters.
- Regions:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - image = h_cnt<IMG_W·SCALE && v_cnt<IMG_H·SCALE.
- Address generation uses no dividers:
  - Sub-counters sx and sy run 0..SCALE−1.
  - img_x advances when sx wraps. img_y advances when sy wraps at end of line.
  - line_base accumulates IMG_W per image row.
  - rd_addr = bank·IMG_W·IMG_H + line_base + img_x.
  - Outside the image region, rd_addr holds its last value.
- Colour mapping:
  - In image: gray = rd_data[DEPTH−1 -: 3], and r = g = b = gray.
  - Active but outside image: BORDER.
  - Outside active: 0.
- Bank swap:
  - Evaluated on the pix_ce where h_cnt==0 and v_cnt==V_ACTIVE (start of vblank).
  - If swap_req=1 there, bank toggles and swap_ack pulses in that same ClkPort cycle.
  - swap_req at any other time is held pending until the next evaluation point.
  - The requester drops swap_req after swap_ack. If swap_req is still high at the next vblank, the bank toggles again.
- frame_start pulses on the pix_ce with h_cnt==0 and v_cnt==0.

## Timing
- Pipeline, 2 pixel slots:
  - Slot 0: counters.
  - Slot 1: rd_addr registered, region and sync flags delayed.
  - Slot 2: colour registered from rd_data.
- Syncs are delayed by the same 2 slots, so sync and colour stay aligned.
- rd_data is sampled CLK_DIV−1 ≥ 1 cycles after rd_addr changes.
- frame_start and swap_ack are undelayed (slot 0 timing).
- Reset values:
  - Counters, bank, rd_addr, colour, swap_ack, frame_start: 0.
  - vga_h_sync, vga_v_sync: 1.
- Reset mid-operation: all state returns to the reset values immediately. The first pix_ce after release is h_cnt=0, v_cnt=0, and frame_start pulses there.
- A swap evaluation and the frame wrap never coincide, because V_ACTIVE>0.

## Structure
- Package vga_pkg holds:
  - Default timing constants.
  - H_TOTAL and V_TOTAL functions.
  - gray_map function (DEPTH→3 bits).
  - Colour struct {r,g,b}.
- Sub-module vga_timing_gen holds the pix_ce divider, h/v counters, syncs, active flag and frame_start.
- vga_frame_scanner adds address generation, bank swap and the colour pipeline.

## Test plan
- Reset: hold reset_n=0 → syncs=1, colour=0, rd_addr=0. Release → frame_start pulses on the first pix_ce.
- Line timing, defaults: hsync period = 3200 ClkPort cycles, low for 384 cycles starting at pixel 656+2. Frame = 1,680,000 cycles.
- Scan addressing: line 0 rd_addr = 0,0,1,1,…,159,159. Line 1 repeats line 0. Line 2 starts at 160. Last image pixel = 19199.
- Regions, with rd_data=4'hF: pixel (100,10) → r=g=b=7. Pixel (400,10) → BORDER. Pixel (700,10) → 0.
- Swap: assert swap_req at v_cnt=100 → swap_ack at v_cnt=480, h_cnt=0. The next frame's first rd_addr = 19200.
- Mid-line reset at h_cnt=300 → counters restart at 0 and bank=0. The pending swap_req is honoured at the next vblank.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, colour payload and helpers for the VGA scan path.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Top three bits of a depth-bit pixel become the 3-bit gray level.
    function automatic logic [2:0] gray_map(input logic [15:0] data, input int unsigned depth);
        return 3'(data >> (depth - 3));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, raster counters, syncs, active flag and frame_start.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10
) (
    input  logic          ClkPort,
    input  logic          reset_n,
    output logic          pix_ce_c,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_last_c,
    output logic          v_last_c,
    output logic          hsync_c,
    output logic          vsync_c,
    output logic          active_c,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DW      = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;

    // Count 0 is the pixel enable, so the first enable after reset lands on pixel (0,0).
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pix_ce_c = (div_cnt == '0);
    assign h_last_c = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last_c = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce_c && (h_cnt == '0) && (v_cnt == '0);
            if (pix_ce_c) begin
                if (h_last_c) begin
                    h_cnt <= '0;
                    v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    assign hsync_c  = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_c  = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA controller: scans a double-buffered multi-bit image with integer upscaling.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned IMG_W    = 160,
    parameter int unsigned IMG_H    = 120,
    parameter int unsigned SCALE    = 2,
    parameter int unsigned DEPTH    = 4,
    parameter logic [8:0]  BORDER   = 9'b000_000_011,
    parameter int unsigned ADDR_W   = $clog2(2 * IMG_W * IMG_H)
) (
    input  logic              ClkPort,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DEPTH-1:0]  rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              frame_start,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic [2:0]        vga_r,
    output logic [2:0]        vga_g,
    output logic [2:0]        vga_b
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned XW      = $clog2(IMG_W + 1);
    localparam int unsigned SW      = $clog2(SCALE + 1);
    localparam int unsigned PIX_W   = IMG_W * SCALE;
    localparam int unsigned PIX_H   = IMG_H * SCALE;
    localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(IMG_W * IMG_H);

    logic          pix_ce;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          hsync_c;
    logic          vsync_c;
    logic          active_c;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CLK_DIV  (CLK_DIV),  .HW   (HW),   .VW     (VW)
    ) u_timing (
        .ClkPort     (ClkPort),
        .reset_n     (reset_n),
        .pix_ce_c    (pix_ce),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_last_c    (h_last),
        .v_last_c    (v_last),
        .hsync_c     (hsync_c),
        .vsync_c     (vsync_c),
        .active_c    (active_c),
        .frame_start (frame_start)
    );

    logic [SW-1:0]     sx;
    logic [SW-1:0]     sy;
    logic [XW-1:0]     img_x;
    logic [ADDR_W-1:0] line_base;
    logic              bank;
    logic              in_img_c;
    logic              x_more_c;
    logic              y_more_c;
    logic              swap_eval_c;

    assign in_img_c    = (h_cnt < HW'(PIX_W)) && (v_cnt < VW'(PIX_H));
    assign x_more_c    = (h_cnt < HW'(PIX_W - 1));
    assign y_more_c    = (v_cnt < VW'(PIX_H - 1));
    assign swap_eval_c = pix_ce && (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

    // Sub-counters track the pixel currently held in h_cnt/v_cnt; they only step while
    // another image column/row follows, so img_x and line_base never leave the image.
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            sx        <= '0;
            img_x     <= '0;
            sy        <= '0;
            line_base <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                sx    <= '0;
                img_x <= '0;
                if (v_last) begin
                    sy        <= '0;
                    line_base <= '0;
                end else if (y_more_c) begin
                    if (sy == SW'(SCALE - 1)) begin
                        sy        <= '0;
                        line_base <= line_base + ADDR_W'(IMG_W);
                    end else begin
                        sy <= sy + SW'(1);
                    end
                end
            end else if (x_more_c) begin
                if (sx == SW'(SCALE - 1)) begin
                    sx    <= '0;
                    img_x <= img_x + XW'(1);
                end else begin
                    sx <= sx + SW'(1);
                end
            end
        end
    end

    // Bank flips only at the start of vblank so a frame never mixes buffers.
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            bank     <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap_eval_c && swap_req;
            if (swap_eval_c && swap_req) begin
                bank <= ~bank;
            end
        end
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr <= '0;
        end else if (pix_ce && in_img_c) begin
            rd_addr <= (bank ? BANK_SIZE : '0) + line_base + ADDR_W'(img_x);
        end
    end

    logic       img_d;
    logic       act_d;
    logic       hs_d;
    logic       vs_d;
    rgb_t       colour;
    logic [2:0] gray_c;

    assign gray_c = gray_map(16'(rd_data), DEPTH);

    // Two-slot pipeline: flags follow rd_addr, then colour and syncs leave together.
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            img_d      <= 1'b0;
            act_d      <= 1'b0;
            hs_d       <= 1'b1;
            vs_d       <= 1'b1;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
            colour     <= '0;
        end else if (pix_ce) begin
            img_d      <= in_img_c;
            act_d      <= active_c;
            hs_d       <= hsync_c;
            vs_d       <= vsync_c;
            vga_h_sync <= hs_d;
            vga_v_sync <= vs_d;
            if (img_d) begin
                colour <= rgb_t'({gray_c, gray_c, gray_c});
            end else if (act_d) begin
                colour <= rgb_t'(BORDER);
            end else begin
                colour <= '0;
            end
        end
    end

    assign vga_r = colour.r;
    assign vga_g = colour.g;
    assign vga_b = colour.b;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner on a shrunk 24x16 raster, 4x3 image, scale 2.
module tb_vga_frame_scanner;

    // Raster 24x16 pixels at 2 clocks per pixel: frame = 768 clocks, bank = 12 words.
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;

    logic       mem_mode;
    logic [3:0] fixed_data;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    vga_frame_scanner #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV  (2),  .IMG_W (4), .IMG_H (3), .SCALE (2), .DEPTH (4),
        .BORDER   (9'b000_000_011)
    ) dut (
        .ClkPort     (clk),
        .reset_n     (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .vga_h_sync  (hs),
        .vga_v_sync  (vs),
        .vga_r       (r),
        .vga_g       (g),
        .vga_b       (b)
    );

    always #5 clk = ~clk;

    // Frame memory with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (mem_mode) rd_data <= {rd_addr[2:0], 1'b0};
        else          rd_data <= fixed_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return 32'({r, g, b});
    endfunction

    // pos counts clocks since the frame_start edge; pixel p's rd_addr is seen at 2p,
    // its colour/syncs at 2p+2.
    task automatic seek(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic next_frame();
        seek(768);
        pos = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hs"}, 32'(hs), 1);
        check({tag, "_vs"}, 32'(vs), 1);
        check({tag, "_rgb"}, rgb(), 0);
        check({tag, "_addr"}, 32'(rd_addr), 0);
        check({tag, "_ack"}, 32'(swap_ack), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        swap_req   = 1'b0;
        mem_mode   = 1'b0;
        fixed_data = 4'hF;
        repeat (4) @(negedge clk);
        check_reset_state("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        pos = 0;

        // Frame A: constant data 0xF, timing, addressing and regions.
        check("a_fs_first", 32'(frame_start), 1);
        check("a_addr_0_0", 32'(rd_addr), 0);
        seek(2);   check("a_addr_1_0", 32'(rd_addr), 0);
        seek(4);   check("a_addr_2_0", 32'(rd_addr), 1);
        seek(14);  check("a_addr_7_0", 32'(rd_addr), 3);
        seek(20);  check("a_addr_hold", 32'(rd_addr), 3);
        seek(36);  check("a_hs_17", 32'(hs), 1);
        seek(38);  check("a_hs_18", 32'(hs), 0);
        seek(42);  check("a_hs_20", 32'(hs), 0);
        seek(44);  check("a_hs_21", 32'(hs), 1);
        seek(48);  check("a_addr_0_1", 32'(rd_addr), 0);
        seek(54);  check("a_addr_3_1", 32'(rd_addr), 1);
        seek(56);  check("a_rgb_img", rgb(), 9'o777);
        seek(74);  check("a_rgb_border", rgb(), 9'o003);
        seek(90);  check("a_rgb_blank", rgb(), 0);
        seek(96);  check("a_addr_0_2", 32'(rd_addr), 4);
        seek(106); check("a_addr_5_2", 32'(rd_addr), 6);
        seek(254); check("a_addr_last", 32'(rd_addr), 11);
        seek(300); swap_req = 1'b1;
        seek(502); check("a_rgb_border_v10", rgb(), 9'o003);
        seek(574); check("a_ack_before", 32'(swap_ack), 0);
        seek(576); check("a_ack_pulse", 32'(swap_ack), 1);
        seek(577); check("a_ack_after", 32'(swap_ack), 0);
        swap_req = 1'b0;
        seek(632); check("a_rgb_vblank", rgb(), 0);
                   check("a_vs_13", 32'(vs), 0);
        seek(720); check("a_vs_14", 32'(vs), 0);
        seek(722); check("a_vs_15", 32'(vs), 1);
        seek(766); check("a_fs_idle", 32'(frame_start), 0);
        next_frame();

        // Frame B: bank 1 and address-dependent data.
        check("b_fs", 32'(frame_start), 1);
        check("b_addr_0_0", 32'(rd_addr), 12);
        mem_mode = 1'b1;
        seek(4);   check("b_addr_2_0", 32'(rd_addr), 13);
        seek(56);  check("b_rgb_3_1", rgb(), 9'o555);
        seek(100); swap_req = 1'b1;
        seek(110); check("b_rgb_6_2", rgb(), 9'o333);
        seek(164); rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pos = 0;

        // Frame C: after mid-line reset, bank back to 0 and held request honoured.
        check("c_fs_first", 32'(frame_start), 1);
        seek(4);   check("c_addr_2_0", 32'(rd_addr), 1);
        seek(56);  check("c_rgb_3_1", rgb(), 9'o111);
        seek(574); check("c_ack_before", 32'(swap_ack), 0);
        seek(576); check("c_ack_pulse", 32'(swap_ack), 1);
        seek(577); swap_req = 1'b0;
        next_frame();

        // Frame D: bank 1 stays, no further swap.
        check("d_fs", 32'(frame_start), 1);
        check("d_addr_0_0", 32'(rd_addr), 12);
        seek(4);   check("d_addr_2_0", 32'(rd_addr), 13);
        seek(576); check("d_ack_none", 32'(swap_ack), 0);
        next_frame();
        check("e_addr_0_0", 32'(rd_addr), 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
